// File: rtl/ctrl_pkg.sv
// Shared constants for the microprogrammed control unit: sequencing codes,
// condition selects, opcodes and dispatch targets (also used by microstore generation).
package ctrl_pkg;

  localparam int SW_DEFAULT          = 7;
  localparam int MOC_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] NS_DISPATCH = 3'b000;
  localparam logic [2:0] NS_FETCH    = 3'b001;
  localparam logic [2:0] NS_JUMP     = 3'b010;
  localparam logic [2:0] NS_INC      = 3'b011;
  localparam logic [2:0] NS_BRANCH   = 3'b100;
  localparam logic [2:0] NS_HOLD     = 3'b101;
  localparam logic [2:0] NS_CALL     = 3'b110;
  localparam logic [2:0] NS_RETURN   = 3'b111;

  localparam logic [1:0] CS_MOC   = 2'b00;
  localparam logic [1:0] CS_ALU_Z = 2'b01;
  localparam logic [1:0] CS_ALU_N = 2'b10;
  localparam logic [1:0] CS_ONE   = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [6:0] ST_RTYPE = 7'd6;
  localparam logic [6:0] ST_LW    = 7'd7;
  localparam logic [6:0] ST_SW    = 7'd13;
  localparam logic [6:0] ST_BEQ   = 7'd11;
  localparam logic [6:0] ST_ADDI  = 7'd16;
  localparam logic [6:0] ST_LUI   = 7'd18;
  localparam logic [6:0] ST_J     = 7'd12;

endpackage

// File: rtl/dispatch_encoder.sv
// Combinational opcode-to-microstate decoder; anything unrecognised lands on ILLEGAL_ST.
module dispatch_encoder
  import ctrl_pkg::*;
#(
  parameter int             SW         = SW_DEFAULT,
  parameter logic [SW-1:0]  ILLEGAL_ST = '0
) (
  input  logic [5:0]    opcode,
  output logic [SW-1:0] target
);

  always_comb begin
    target = ILLEGAL_ST;
    case (opcode)
      OP_RTYPE: target = SW'(ST_RTYPE);
      OP_LW:    target = SW'(ST_LW);
      OP_SW:    target = SW'(ST_SW);
      OP_BEQ:   target = SW'(ST_BEQ);
      OP_ADDI:  target = SW'(ST_ADDI);
      OP_LUI:   target = SW'(ST_LUI);
      OP_J:     target = SW'(ST_J);
      default:  target = ILLEGAL_ST;
    endcase
  end

endmodule

// File: rtl/microsequencer.sv
// Microsequencer: state register, 1-deep call/return, condition mux and
// next-state selection, plus a watchdog that traps stuck memory waits.
module microsequencer
  import ctrl_pkg::*;
#(
  parameter int            SW          = SW_DEFAULT,
  parameter int            MOC_TIMEOUT = MOC_TIMEOUT_DEFAULT,
  parameter logic [SW-1:0] FETCH_STATE = SW'(1),
  parameter logic [SW-1:0] TRAP_STATE  = SW'(0),
  parameter logic [SW-1:0] ILLEGAL_ST  = SW'(0)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    next_sel,
  input  logic          inv,
  input  logic [1:0]    cond_sel,
  input  logic [SW-1:0] cr_addr,
  input  logic [5:0]    opcode,
  input  logic          moc,
  input  logic          alu_z,
  input  logic          alu_n,
  output logic [SW-1:0] state,
  output logic          bus_err
);

  localparam int CW = $clog2(MOC_TIMEOUT + 1);

  logic [SW-1:0] ret_reg;
  logic [SW-1:0] ret_next;
  logic [SW-1:0] inc;
  logic [SW-1:0] dispatch_state;
  logic [SW-1:0] next_state;
  logic [CW-1:0] to_cnt;
  logic [CW-1:0] to_cnt_next;
  logic          cond_raw;
  logic          c;
  logic          moc_hold;
  logic          trap;

  dispatch_encoder #(
    .SW         (SW),
    .ILLEGAL_ST (ILLEGAL_ST)
  ) u_dispatch (
    .opcode (opcode),
    .target (dispatch_state)
  );

  always_comb begin
    cond_raw = 1'b1;
    case (cond_sel)
      CS_MOC:   cond_raw = moc;
      CS_ALU_Z: cond_raw = alu_z;
      CS_ALU_N: cond_raw = alu_n;
      default:  cond_raw = 1'b1;
    endcase
  end

  assign c        = cond_raw ^ inv;
  assign inc      = state + SW'(1);
  assign moc_hold = (next_sel == NS_HOLD) && (cond_sel == CS_MOC) && c;
  assign trap     = moc_hold && (to_cnt == CW'(MOC_TIMEOUT - 1));

  // Trap wins over the hold; the counter only survives consecutive MOC-hold cycles.
  always_comb begin
    next_state  = state;
    ret_next    = ret_reg;
    to_cnt_next = '0;
    case (next_sel)
      NS_DISPATCH: next_state = dispatch_state;
      NS_FETCH:    next_state = FETCH_STATE;
      NS_JUMP:     next_state = cr_addr;
      NS_INC:      next_state = inc;
      NS_BRANCH:   next_state = c ? cr_addr : inc;
      NS_HOLD:     next_state = c ? state : inc;
      NS_CALL: begin
        next_state = cr_addr;
        ret_next   = inc;
      end
      NS_RETURN:   next_state = ret_reg;
      default:     next_state = FETCH_STATE;
    endcase
    if (trap) begin
      next_state  = TRAP_STATE;
      to_cnt_next = '0;
    end else if (moc_hold) begin
      to_cnt_next = to_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= '0;
      ret_reg <= FETCH_STATE;
      to_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      state   <= next_state;
      ret_reg <= ret_next;
      to_cnt  <= to_cnt_next;
      bus_err <= trap;
    end
  end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios followed by random
// traffic, all compared against a behavioural model of the sequencing rules.
module tb_microsequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] next_sel;
  logic       inv;
  logic [1:0] cond_sel;
  logic [6:0] cr_addr;
  logic [5:0] opcode;
  logic       moc;
  logic       alu_z;
  logic       alu_n;
  logic [6:0] state;
  logic       bus_err;

  int assertCount = 0;
  int failCount   = 0;

  int mState;
  int mRet;
  int mHoldCycles;
  int mBusErr;
  int dispatchTable [64];

  always #5 clk = ~clk;

  microsequencer dut (
    .clk      (clk),
    .reset    (reset),
    .next_sel (next_sel),
    .inv      (inv),
    .cond_sel (cond_sel),
    .cr_addr  (cr_addr),
    .opcode   (opcode),
    .moc      (moc),
    .alu_z    (alu_z),
    .alu_n    (alu_n),
    .state    (state),
    .bus_err  (bus_err)
  );

  // Reference: a memory wait may last 15 stalled cycles; the 16th consecutive one traps.
  task automatic modelStep();
    int cond;
    int incv;
    bit mocWait;
    if (reset) begin
      mState = 0; mRet = 1; mHoldCycles = 0; mBusErr = 0;
      return;
    end
    case (cond_sel)
      2'd0: cond = moc;
      2'd1: cond = alu_z;
      2'd2: cond = alu_n;
      default: cond = 1;
    endcase
    cond    = cond ^ int'(inv);
    incv    = (mState + 1) % 128;
    mocWait = (next_sel == 3'd5) && (cond_sel == 2'd0) && (cond == 1);
    mBusErr = 0;
    if (mocWait && mHoldCycles == 15) begin
      mState = 0; mBusErr = 1; mHoldCycles = 0;
      return;
    end
    mHoldCycles = mocWait ? mHoldCycles + 1 : 0;
    case (next_sel)
      3'd0: mState = dispatchTable[opcode];
      3'd1: mState = 1;
      3'd2: mState = cr_addr;
      3'd3: mState = incv;
      3'd4: mState = cond ? int'(cr_addr) : incv;
      3'd5: mState = cond ? mState : incv;
      3'd6: begin mRet = incv; mState = cr_addr; end
      default: mState = mRet;
    endcase
  endtask

  task automatic applyStimulus(input logic rst, input logic [2:0] ns, input logic iv,
                               input logic [1:0] cs, input logic [6:0] cr, input logic [5:0] op,
                               input logic m, input logic z, input logic n);
    reset = rst; next_sel = ns; inv = iv; cond_sel = cs; cr_addr = cr;
    opcode = op; moc = m; alu_z = z; alu_n = n;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [6:0] expState;
    logic       expErr;
    expState = 7'(mState);
    expErr   = (mBusErr != 0);
    assertCount++;
    assert (state === expState) else begin
      failCount++;
      $error("FAIL %s state: observed %0d expected %0d", tag, state, expState);
    end
    assertCount++;
    assert (bus_err === expErr) else begin
      failCount++;
      $error("FAIL %s bus_err: observed %0b expected %0b", tag, bus_err, expErr);
    end
  endtask

  initial begin
    int len;
    int breakAt;
    for (int i = 0; i < 64; i++) dispatchTable[i] = 0;
    dispatchTable[6'h00] = 6;  dispatchTable[6'h23] = 7;  dispatchTable[6'h2B] = 13;
    dispatchTable[6'h04] = 11; dispatchTable[6'h08] = 16; dispatchTable[6'h0F] = 18;
    dispatchTable[6'h02] = 12;
    mState = 0; mRet = 1; mHoldCycles = 0; mBusErr = 0;

    // Reset, then fetch.
    applyStimulus(1, 3'd1, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("reset1");
    applyStimulus(1, 3'd1, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("reset2");
    applyStimulus(0, 3'd1, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("fetch");

    // Dispatch.
    applyStimulus(0, 3'd0, 0, 2'd0, 7'd0, 6'h23, 0, 0, 0); checkOutput("dispatch_lw");
    applyStimulus(0, 3'd0, 0, 2'd0, 7'd0, 6'h3F, 0, 0, 0); checkOutput("dispatch_illegal");
    for (int k = 0; k < 7; k++) begin
      logic [5:0] ops [7];
      ops = '{6'h00, 6'h2B, 6'h04, 6'h08, 6'h0F, 6'h02, 6'h11};
      applyStimulus(0, 3'd0, 0, 2'd0, 7'd0, ops[k], 0, 0, 0); checkOutput("dispatch_table");
    end

    // Conditional branch on alu_z, with and without inversion.
    applyStimulus(0, 3'd4, 0, 2'd1, 7'd20, 6'h00, 0, 1, 0); checkOutput("br_z1");
    applyStimulus(0, 3'd4, 0, 2'd1, 7'd20, 6'h00, 0, 0, 0); checkOutput("br_z0");
    applyStimulus(0, 3'd4, 1, 2'd1, 7'd20, 6'h00, 0, 1, 0); checkOutput("br_inv_z1");
    applyStimulus(0, 3'd4, 1, 2'd1, 7'd20, 6'h00, 0, 0, 0); checkOutput("br_inv_z0");
    applyStimulus(0, 3'd4, 0, 2'd2, 7'd33, 6'h00, 0, 0, 1); checkOutput("br_n1");

    // MOC wait timing out: 15 holds, then trap with a single bus_err pulse.
    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("moc_hold");
    end
    applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("moc_trap");
    applyStimulus(0, 3'd3, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("after_trap");

    // MOC arrives on cycle 5, clearing the counter for the next wait.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("moc_short_hold");
    end
    applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 1, 0, 0); checkOutput("moc_done");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("moc_rehold");
    end

    // Non-MOC hold never times out.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 3'd5, 0, 2'd3, 7'd0, 6'h00, 0, 0, 0); checkOutput("const_hold");
    end

    // Call/return and increment wrap.
    applyStimulus(0, 3'd2, 0, 2'd0, 7'd9, 6'h00, 0, 0, 0);   checkOutput("jump9");
    applyStimulus(0, 3'd6, 0, 2'd0, 7'd40, 6'h00, 0, 0, 0);  checkOutput("call40");
    applyStimulus(0, 3'd3, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0);   checkOutput("inc_in_sub");
    applyStimulus(0, 3'd7, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0);   checkOutput("return10");
    applyStimulus(0, 3'd2, 0, 2'd0, 7'd127, 6'h00, 0, 0, 0); checkOutput("jump127");
    applyStimulus(0, 3'd3, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0);   checkOutput("wrap");
    applyStimulus(0, 3'd6, 0, 2'd0, 7'd50, 6'h00, 0, 0, 0);  checkOutput("call_a");
    applyStimulus(0, 3'd6, 0, 2'd0, 7'd70, 6'h00, 0, 0, 0);  checkOutput("call_b");
    applyStimulus(0, 3'd7, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0);   checkOutput("return_b");

    // Reset during a wait clears the counter; a fresh wait needs all 16 cycles.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("pre_reset_hold");
    end
    applyStimulus(1, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("reset_mid_hold");
    applyStimulus(0, 3'd7, 0, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("return_no_call");
    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("post_reset_hold");
    end
    applyStimulus(0, 3'd5, 1, 2'd0, 7'd0, 6'h00, 0, 0, 0); checkOutput("post_reset_trap");

    // Random traffic mixing free sequencing with long MOC waits.
    for (int seg = 0; seg < 60; seg++) begin
      if ($urandom_range(0, 2) == 0) begin
        len     = $urandom_range(10, 20);
        breakAt = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, len - 1)) : -1;
        for (int k = 0; k < len; k++) begin
          logic iv;
          iv = 1'($urandom_range(0, 1));
          applyStimulus(0, 3'd5, iv, 2'd0, 7'($urandom), 6'($urandom),
                        (k == breakAt) ? iv : ~iv, 1'($urandom), 1'($urandom));
          checkOutput("rand_wait");
        end
      end else begin
        for (int k = 0; k < 6; k++) begin
          applyStimulus(($urandom_range(0, 39) == 0), 3'($urandom), 1'($urandom),
                        2'($urandom), 7'($urandom), 6'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom));
          checkOutput("rand_step");
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
